div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit.sv | 261 ++++++++++++++++++++++++++
 tb/tb_div_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: 32-bit integer divider (DIV/DIVU/REM/REMU), radix-2 restoring, one bit per cycle.
// Latency: result strobe in the 33rd cycle after the accept edge (1 cycle for trivial cases when DIV_EARLY_OUT_EN).
// Backpressure: issue_ready only while IDLE; writeback cannot stall the result, which is presented for one cycle.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   issue_valid / issue_ready     operation handshake (ready == state is IDLE)
//   issue_op                      0=DIV, 1=DIVU, 2=REM, 3=REMU
//   issue_src1 / issue_src2       dividend / divisor
//   issue_rd_enable / issue_rd_phy destination register info carried through to writeback
//   commit_flush                  discards any in-flight operation, returns to IDLE
//   div_wb_port_data_out / _we    writeback packet and its valid strobe
//
// Optional feature: define DIV_EARLY_OUT_EN to skip the iteration loop for divide-by-zero,
// signed overflow and |src1| < |src2|; those results then appear the cycle after accept.

package div_unit_pkg;
  localparam int REG_DATA_WIDTH   = 32;
  localparam int PHY_REG_ID_WIDTH = 6;

  typedef struct packed {
    logic                        enable;
    logic                        valid;
    logic                        has_exception;
    logic                        need_rename;
    logic                        rd_enable;
    logic [PHY_REG_ID_WIDTH-1:0] rd_phy;
    logic [REG_DATA_WIDTH-1:0]   rd_value;
  } execute_wb_pack_t;
endpackage

module div_unit
  import div_unit_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        issue_valid,
  output logic                        issue_ready,
  input  logic [1:0]                  issue_op,
  input  logic [REG_DATA_WIDTH-1:0]   issue_src1,
  input  logic [REG_DATA_WIDTH-1:0]   issue_src2,
  input  logic                        issue_rd_enable,
  input  logic [PHY_REG_ID_WIDTH-1:0] issue_rd_phy,
  input  logic                        commit_flush,
  output execute_wb_pack_t            div_wb_port_data_out,
  output logic                        div_wb_port_we
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t                      state_q,      state_d;
  logic [4:0]                  cnt_q,        cnt_d;
  logic [1:0]                  op_q,         op_d;
  logic [REG_DATA_WIDTH-1:0]   src1_q,       src1_d;      // raw dividend, needed for x/0 remainder
  logic [REG_DATA_WIDTH-1:0]   dsr_q,        dsr_d;       // divisor magnitude
  logic [REG_DATA_WIDTH-1:0]   qd_q,         qd_d;        // dividend shifts out of the top, quotient in at the bottom
  logic [REG_DATA_WIDTH-1:0]   pr_q,         pr_d;        // partial remainder, always < divisor
  logic                        rd_enable_q,  rd_enable_d;
  logic [PHY_REG_ID_WIDTH-1:0] rd_phy_q,     rd_phy_d;
  logic                        q_neg_q,      q_neg_d;
  logic                        r_neg_q,      r_neg_d;
  logic                        div_zero_q,   div_zero_d;
  logic                        ovf_q,        ovf_d;

  // ---------------------------------------------------------------------------
  // Issue-side operand decode
  // ---------------------------------------------------------------------------
  logic                      accept;
  logic                      in_signed;
  logic                      src1_neg;
  logic                      src2_neg;
  logic [REG_DATA_WIDTH-1:0] src1_mag;
  logic [REG_DATA_WIDTH-1:0] src2_mag;
  logic                      div_zero_in;
  logic                      ovf_in;

  // A flush on the same edge as a handshake wins: nothing is captured.
  assign accept    = issue_valid && (state_q == IDLE) && !commit_flush;
  assign in_signed = ~issue_op[0];
  assign src1_neg  = in_signed & issue_src1[REG_DATA_WIDTH-1];
  assign src2_neg  = in_signed & issue_src2[REG_DATA_WIDTH-1];
  // 0x80000000 negates to itself, which is the correct unsigned magnitude.
  assign src1_mag  = src1_neg ? (~issue_src1 + 32'd1) : issue_src1;
  assign src2_mag  = src2_neg ? (~issue_src2 + 32'd1) : issue_src2;

  assign div_zero_in = (issue_src2 == '0);
  assign ovf_in      = in_signed && (issue_src1 == 32'h8000_0000) && (issue_src2 == 32'hFFFF_FFFF);

`ifdef DIV_EARLY_OUT_EN
  logic early_in;
  // Quotient is 0 and remainder is the dividend whenever |src1| < |src2|, so no iteration is needed.
  assign early_in = div_zero_in | ovf_in | (src1_mag < src2_mag);
`endif

  // ---------------------------------------------------------------------------
  // One restoring step: shift the next dividend bit into the remainder and
  // subtract the divisor if it fits.
  // ---------------------------------------------------------------------------
  logic [REG_DATA_WIDTH:0]   shifted;
  logic                      step_ok;
  logic [REG_DATA_WIDTH-1:0] step_diff;

  assign shifted   = {pr_q, qd_q[REG_DATA_WIDTH-1]};
  assign step_ok   = (shifted >= {1'b0, dsr_q});
  // When the subtraction is taken the true difference is below the divisor, so 32 bits hold it.
  assign step_diff = shifted[REG_DATA_WIDTH-1:0] - dsr_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    src1_d      = src1_q;
    dsr_d       = dsr_q;
    qd_d        = qd_q;
    pr_d        = pr_q;
    rd_enable_d = rd_enable_q;
    rd_phy_d    = rd_phy_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    div_zero_d  = div_zero_q;
    ovf_d       = ovf_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d     = CALC;
          cnt_d       = 5'd0;
          op_d        = issue_op;
          src1_d      = issue_src1;
          dsr_d       = src2_mag;
          qd_d        = src1_mag;
          pr_d        = '0;
          rd_enable_d = issue_rd_enable;
          rd_phy_d    = issue_rd_phy;
          q_neg_d     = src1_neg ^ src2_neg;
          r_neg_d     = src1_neg;
          div_zero_d  = div_zero_in;
          ovf_d       = ovf_in;
`ifdef DIV_EARLY_OUT_EN
          if (early_in) begin
            // Special cases are resolved by the flags; preloading q=0, r=|src1|
            // gives the right answer for the |src1| < |src2| case.
            state_d = DONE;
            qd_d    = '0;
            pr_d    = src1_mag;
          end
`endif
        end
      end

      CALC: begin
        cnt_d = cnt_q + 5'd1;
        if (step_ok) begin
          pr_d = step_diff;
          qd_d = {qd_q[REG_DATA_WIDTH-2:0], 1'b1};
        end else begin
          pr_d = shifted[REG_DATA_WIDTH-1:0];
          qd_d = {qd_q[REG_DATA_WIDTH-2:0], 1'b0};
        end
        // Counter value 31 means this edge completes the 32nd step.
        if (cnt_q == 5'd31) begin
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (commit_flush) begin
      state_d = IDLE;
      cnt_d   = 5'd0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 5'd0;
      op_q        <= 2'd0;
      src1_q      <= '0;
      dsr_q       <= '0;
      qd_q        <= '0;
      pr_q        <= '0;
      rd_enable_q <= 1'b0;
      rd_phy_q    <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      div_zero_q  <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      src1_q      <= src1_d;
      dsr_q       <= dsr_d;
      qd_q        <= qd_d;
      pr_q        <= pr_d;
      rd_enable_q <= rd_enable_d;
      rd_phy_q    <= rd_phy_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      div_zero_q  <= div_zero_d;
      ovf_q       <= ovf_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Result formation and outputs
  // ---------------------------------------------------------------------------
  logic [REG_DATA_WIDTH-1:0] quot;
  logic [REG_DATA_WIDTH-1:0] rem;

  always_comb begin
    quot = q_neg_q ? (~qd_q + 32'd1) : qd_q;
    rem  = r_neg_q ? (~pr_q + 32'd1) : pr_q;
    if (div_zero_q) begin
      quot = 32'hFFFF_FFFF;
      rem  = src1_q;
    end else if (ovf_q) begin
      quot = 32'h8000_0000;
      rem  = '0;
    end
  end

  always_comb begin
    div_wb_port_data_out = '0;
    if (state_q == DONE) begin
      div_wb_port_data_out.enable        = 1'b1;
      div_wb_port_data_out.valid         = 1'b1;
      div_wb_port_data_out.has_exception = 1'b0;
      div_wb_port_data_out.need_rename   = rd_enable_q;
      div_wb_port_data_out.rd_enable     = rd_enable_q;
      div_wb_port_data_out.rd_phy        = rd_phy_q;
      div_wb_port_data_out.rd_value      = op_q[1] ? rem : quot;
    end
  end

  // A flush in the DONE cycle suppresses the strobe combinationally.
  assign div_wb_port_we = (state_q == DONE) && !commit_flush;
  assign issue_ready    = (state_q == IDLE);

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit.
// Expected results are queued at accept and popped when the writeback strobe fires.
// Latency, packet fields, idle-zero output, flush and reset behaviour are all compared.

module tb_div_unit;
  import div_unit_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             issue_valid;
  logic             issue_ready;
  logic [1:0]       issue_op;
  logic [31:0]      issue_src1;
  logic [31:0]      issue_src2;
  logic             issue_rd_enable;
  logic [5:0]       issue_rd_phy;
  logic             commit_flush;
  execute_wb_pack_t div_wb_port_data_out;
  logic             div_wb_port_we;

  div_unit dut (
    .clk                  (clk),
    .rst                  (rst),
    .issue_valid          (issue_valid),
    .issue_ready          (issue_ready),
    .issue_op             (issue_op),
    .issue_src1           (issue_src1),
    .issue_src2           (issue_src2),
    .issue_rd_enable      (issue_rd_enable),
    .issue_rd_phy         (issue_rd_phy),
    .commit_flush         (commit_flush),
    .div_wb_port_data_out (div_wb_port_data_out),
    .div_wb_port_we       (div_wb_port_we)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] val;
    logic [5:0]  phy;
    logic        en;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   cyc     = 0;
  int   checks  = 0;
  int   errors  = 0;
  int   we_seen = 0;
  int   n_push  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb_, sq, sr;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
    if (!op[0]) begin
      sa  = $signed(a);
      sb_ = $signed(b);
      sq  = sa / sb_;
      sr  = sa % sb_;
      return op[1] ? 32'(sr) : 32'(sq);
    end
    return op[1] ? (a % b) : (a / b);
  endfunction

  function automatic int exp_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
    logic [31:0] ma, mb;
    ma = (!op[0] && a[31]) ? (~a + 32'd1) : a;
    mb = (!op[0] && b[31]) ? (~b + 32'd1) : b;
    if (b == 32'd0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) || ma < mb) return 1;
`else
    if (op == 2'd3 && a == 32'hDEAD_BEEF && b == 32'hDEAD_BEEF) return 33;
`endif
    return 33;
  endfunction

  // Waits (bounded) for issue_ready, offers one op, and queues its expected result if push is set.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic en, input logic [5:0] phy, input bit push);
    int   n = 0;
    exp_t e;
    @(negedge clk);
    while (!issue_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!issue_ready) begin
      chk_eq("ready_timeout", {63'd0, issue_ready}, 64'd1);
      return;
    end
    issue_op        = op;
    issue_src1      = a;
    issue_src2      = b;
    issue_rd_enable = en;
    issue_rd_phy    = phy;
    issue_valid     = 1'b1;
    @(posedge clk);
    #1;
    issue_valid = 1'b0;
    if (push) begin
      e.val = model(op, a, b);
      e.phy = phy;
      e.en  = en;
      e.acc = cyc;
      e.lat = exp_lat(op, a, b);
      sb.push_back(e);
      n_push++;
    end
  endtask

  // Scoreboard consumer and idle-output check.
  always @(negedge clk) begin
    exp_t e;
    if (div_wb_port_we) begin
      we_seen++;
      if (sb.size() == 0) begin
        chk_eq("spurious_we", {63'd0, div_wb_port_we}, 64'd0);
      end else begin
        e = sb.pop_front();
        chk_eq("rd_value",    {32'd0, div_wb_port_data_out.rd_value}, {32'd0, e.val});
        chk_eq("rd_phy",      {58'd0, div_wb_port_data_out.rd_phy}, {58'd0, e.phy});
        chk_eq("rd_enable",   {63'd0, div_wb_port_data_out.rd_enable}, {63'd0, e.en});
        chk_eq("need_rename", {63'd0, div_wb_port_data_out.need_rename}, {63'd0, e.en});
        chk_eq("wb_flags",    {61'd0, div_wb_port_data_out.enable, div_wb_port_data_out.valid,
                               div_wb_port_data_out.has_exception}, 64'b110);
        chk_eq("latency",     64'(cyc - e.acc + 1), 64'(e.lat));
      end
    end else if (!commit_flush) begin
      chk_eq("idle_zero", 64'(div_wb_port_data_out), 64'd0);
    end
  end

  initial begin
    int n;
    rst             = 1'b1;
    issue_valid     = 1'b0;
    issue_op        = 2'd0;
    issue_src1      = '0;
    issue_src2      = '0;
    issue_rd_enable = 1'b0;
    issue_rd_phy    = '0;
    commit_flush    = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk_eq("rst_ready", {63'd0, issue_ready}, 64'd1);
    chk_eq("rst_we",    {63'd0, div_wb_port_we}, 64'd0);
    chk_eq("rst_data",  64'(div_wb_port_data_out), 64'd0);
    rst = 1'b0;

    // Directed results
    issue(2'd1, 32'd100, 32'd7, 1'b1, 6'd5, 1'b1);          // DIVU -> 14
    issue(2'd3, 32'd100, 32'd7, 1'b1, 6'd5, 1'b1);          // REMU -> 2
    issue(2'd0, 32'hFFFF_FFF9, 32'd2, 1'b1, 6'd7, 1'b1);    // DIV  -> 0xFFFFFFFD
    issue(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 6'd8, 1'b1);    // REM  -> 0xFFFFFFFF
    issue(2'd0, 32'd5, 32'd0, 1'b1, 6'd9, 1'b1);            // DIV by zero
    issue(2'd2, 32'd5, 32'd0, 1'b1, 6'd10, 1'b1);           // REM by zero
    issue(2'd1, 32'd77, 32'd0, 1'b1, 6'd11, 1'b1);          // DIVU by zero
    issue(2'd3, 32'hF000_0001, 32'd0, 1'b1, 6'd12, 1'b1);   // REMU by zero
    issue(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 6'd13, 1'b1); // overflow quotient
    issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 6'd14, 1'b1); // overflow remainder
    issue(2'd0, 32'd7, 32'hFFFF_FFFE, 1'b1, 6'd15, 1'b1);   // 7 / -2 -> -3
    issue(2'd2, 32'd7, 32'hFFFF_FFFE, 1'b1, 6'd16, 1'b1);   // 7 % -2 -> 1
    issue(2'd1, 32'd3, 32'd10, 1'b1, 6'd17, 1'b1);          // DIVU 3/10 -> 0
    issue(2'd1, 32'hFFFF_FFFF, 32'd1, 1'b1, 6'd18, 1'b1);   // full-width quotient

    // Random mix
    for (int i = 0; i < 12; i++) begin
      logic [31:0] a, b;
      a = $urandom();
      b = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom();
      issue(2'($urandom_range(0, 3)), a, b, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), 1'b1);
    end

    // Flush on the 10th edge of CALC: no strobe, ready the next cycle
    issue(2'd1, 32'd100, 32'd7, 1'b1, 6'd20, 1'b0);
    repeat (9) @(posedge clk);
    #1 commit_flush = 1'b1;
    @(posedge clk);
    #1 commit_flush = 1'b0;
    chk_eq("flush_calc_ready", {63'd0, issue_ready}, 64'd1);
    repeat (40) @(negedge clk);

    // Flush coincident with an offered op: nothing captured
    @(negedge clk);
    issue_op     = 2'd1;
    issue_src1   = 32'd50;
    issue_src2   = 32'd5;
    issue_valid  = 1'b1;
    commit_flush = 1'b1;
    @(posedge clk);
    #1;
    issue_valid  = 1'b0;
    commit_flush = 1'b0;
    chk_eq("flush_accept_ready", {63'd0, issue_ready}, 64'd1);
    repeat (40) @(negedge clk);

    // Flush during DONE suppresses the strobe
    issue(2'd1, 32'd100, 32'd7, 1'b1, 6'd21, 1'b0);
    repeat (32) @(posedge clk);
    #1;
    chk_eq("done_pre_flush_we", {63'd0, div_wb_port_we}, 64'd1);
    commit_flush = 1'b1;
    #1;
    chk_eq("done_flush_we", {63'd0, div_wb_port_we}, 64'd0);
    @(posedge clk);
    #1 commit_flush = 1'b0;
    chk_eq("done_flush_ready", {63'd0, issue_ready}, 64'd1);

    // Reset mid-CALC, then a fresh op
    issue(2'd1, 32'd100, 32'd7, 1'b1, 6'd22, 1'b0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk_eq("midrst_ready", {63'd0, issue_ready}, 64'd1);
    chk_eq("midrst_we",    {63'd0, div_wb_port_we}, 64'd0);
    chk_eq("midrst_data",  64'(div_wb_port_data_out), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    issue(2'd1, 32'd9, 32'd3, 1'b1, 6'd23, 1'b1);           // DIVU 9/3 -> 3

    // Drain the scoreboard (bounded)
    n = 0;
    while (sb.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    chk_eq("drain",    64'(sb.size()), 64'd0);
    chk_eq("we_count", 64'(we_seen), 64'(n_push));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
